int_generator: RTL and testbench

- External interrupt generator: the responder behind the CPU's interrupt-generator write port (m_int_addr / m_int_byteen).
- Raises the level `interrupt` line into the CPU's HWInt[2].
- Holds the line until software acknowledges it with a store to INT_ADDR. Events that arrive while a request is outstanding are queued.
- Event sources: a programmable periodic tick, plus a `trigger` strobe for system tests.

---
 rtl/int_generator.sv | 119 +++++++++++
 tb/tb_int_generator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_generator.sv
// Interrupt generator that drives the CPU's HWInt[2] level line.
// It raises the line for periodic ticks or trigger strobes and queues events until software acknowledges the request.
module int_generator #(
   parameter logic [31:0] INT_ADDR    = 32'h0000_7F20,
   parameter logic [31:0] PERIOD      = 32'd1000,
   parameter logic [3:0]  HOLDOFF     = 4'd2,
   parameter int          MAX_PENDING = 3,
   parameter int          PCW         = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [31:0]    m_int_addr,
   input  logic [3:0]     m_int_byteen,
   input  logic           trigger,
   output logic           interrupt,
   output logic [PCW-1:0] pending_count,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [PCW-1:0] PEND_MAX = PCW'(MAX_PENDING);

   state_t         state;
   state_t         state_next;
   logic [31:0]    period_cnt;
   logic [3:0]     hold_cnt;
   logic [3:0]     hold_cnt_next;
   logic [PCW-1:0] pending_next;
   logic [PCW-1:0] pending_inc;
   logic           tick;
   logic           evt;
   logic           ack;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^m_int_addr[1:0];

   // The period counter keeps running in every state, so ticks stay evenly spaced no matter how slowly software responds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_cnt <= '0;
      end else if (PERIOD == 32'd0 || period_cnt == PERIOD - 32'd1) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 32'd1;
      end
   end

   assign tick        = (PERIOD != 32'd0) && (period_cnt == PERIOD - 32'd1);
   assign evt         = tick | trigger;
   assign ack         = (m_int_addr[31:2] == INT_ADDR[31:2]) && (m_int_byteen != 4'd0);
   assign pending_inc = (pending_count == PEND_MAX) ? pending_count : pending_count + PCW'(1);

   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      pending_next  = pending_count;
      case (state)
         IDLE: begin
            if (evt) begin
               state_next = ASSERT;
            end else if (pending_count != '0) begin
               state_next   = ASSERT;
               pending_next = pending_count - PCW'(1);
            end
         end
         ASSERT: begin
            if (evt) begin
               pending_next = pending_inc;
            end
            if (ack) begin
               if (HOLDOFF == 4'd0) begin
                  state_next = IDLE;
               end else begin
                  state_next    = HOLD;
                  hold_cnt_next = HOLDOFF;
               end
            end
         end
         HOLD: begin
            if (evt) begin
               pending_next = pending_inc;
            end
            if (hold_cnt <= 4'd1) begin
               state_next    = IDLE;
               hold_cnt_next = 4'd0;
            end else begin
               hold_cnt_next = hold_cnt - 4'd1;
            end
         end
         default: begin
            state_next    = IDLE;
            hold_cnt_next = 4'd0;
         end
      endcase
   end

   // interrupt and busy get their own flops, loaded from the next state, so the CPU sees a clean level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         hold_cnt      <= 4'd0;
         pending_count <= '0;
         interrupt     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_next;
         hold_cnt      <= hold_cnt_next;
         pending_count <= pending_next;
         interrupt     <= (state_next == ASSERT);
         busy          <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_int_generator.sv
// Bench for int_generator: one instance uses a periodic tick and one has ticks disabled.
// A behavioural model of the request line, holdoff window and event queue checks both instances every cycle.
module tb_int_generator;

   localparam int PER_A   = 8;
   localparam int HOLDOFF = 2;
   localparam int MAXP    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m_int_addr;
   logic [3:0]  m_int_byteen;
   logic        trigger;
   logic        a_int, a_busy, b_int, b_busy;
   logic [1:0]  a_pend, b_pend;

   always #5 clk = ~clk;

   int_generator #(.INT_ADDR(32'h0000_7F20), .PERIOD(32'd8), .HOLDOFF(4'd2), .MAX_PENDING(3), .PCW(2)) dut_a (
      .clk(clk), .reset(reset), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
      .trigger(trigger), .interrupt(a_int), .pending_count(a_pend), .busy(a_busy)
   );

   int_generator #(.INT_ADDR(32'h0000_7F20), .PERIOD(32'd0), .HOLDOFF(4'd2), .MAX_PENDING(3), .PCW(2)) dut_b (
      .clk(clk), .reset(reset), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
      .trigger(trigger), .interrupt(b_int), .pending_count(b_pend), .busy(b_busy)
   );

   // high: line requested; quiet: forced-low cycles left after an ack; pend: queued events
   typedef struct {
      int cyc;
      int high;
      int quiet;
      int pend;
   } model_t;

   model_t ma, mb;
   int n_checks = 0;
   int n_pass   = 0;

   function automatic model_t model_step(model_t m, int period, bit trg, bit ack);
      bit ev;
      ev = trg || (period != 0 && (m.cyc % period) == period - 1);
      m.cyc++;
      if (m.high != 0) begin
         if (ev) m.pend = (m.pend < MAXP) ? m.pend + 1 : MAXP;
         if (ack) begin
            m.high  = 0;
            m.quiet = HOLDOFF;
         end
      end else if (m.quiet > 0) begin
         if (ev) m.pend = (m.pend < MAXP) ? m.pend + 1 : MAXP;
         m.quiet--;
      end else if (ev) begin
         m.high = 1;
      end else if (m.pend > 0) begin
         m.pend--;
         m.high = 1;
      end
      return m;
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Inputs change only at negedges, so the model sees the same values the DUTs sample.
   always @(posedge clk) begin
      bit ack_now;
      ack_now = (m_int_addr[31:2] == 30'(32'h7F20 >> 2)) && (m_int_byteen != 4'd0);
      if (reset) begin
         ma = '{default: 0};
         mb = '{default: 0};
      end else begin
         ma = model_step(ma, PER_A, trigger, ack_now);
         mb = model_step(mb, 0, trigger, ack_now);
      end
      #1;
      check_output("a.interrupt", int'(a_int), ma.high);
      check_output("a.busy", int'(a_busy), int'(ma.high != 0 || ma.quiet > 0));
      check_output("a.pending", int'(a_pend), ma.pend);
      check_output("b.interrupt", int'(b_int), mb.high);
      check_output("b.busy", int'(b_busy), int'(mb.high != 0 || mb.quiet > 0));
      check_output("b.pending", int'(b_pend), mb.pend);
   end

   task automatic apply_stimulus(input logic trg, input logic [31:0] addr, input logic [3:0] be);
      trigger      = trg;
      m_int_addr   = addr;
      m_int_byteen = be;
      @(negedge clk);
   endtask

   task automatic step_idle(input int n);
      repeat (n) apply_stimulus(1'b0, 32'd0, 4'd0);
   endtask

   initial begin
      int w;
      int reasserts;
      logic [31:0] addrs [8];
      reset        = 1'b1;
      trigger      = 1'b0;
      m_int_addr   = 32'd0;
      m_int_byteen = 4'd0;
      step_idle(2);
      check_output("reset.interrupt", int'(a_int), 0);
      check_output("reset.busy", int'(a_busy), 0);
      check_output("reset.pending", int'(a_pend), 0);
      reset = 1'b0;

      // First tick: the line rises at the 8th edge after reset release.
      step_idle(7);
      check_output("t1.int_before_tick", int'(a_int), 0);
      step_idle(1);
      check_output("t1.int_at_edge8", int'(a_int), 1);
      check_output("t1.busy", int'(a_busy), 1);
      check_output("t1.pending", int'(a_pend), 0);

      // Ack: the line drops, busy stays high for two holdoff cycles, and the line rises again at the next tick.
      apply_stimulus(1'b0, 32'h7F20, 4'b0001);
      check_output("t2.int_after_ack", int'(a_int), 0);
      check_output("t2.busy_hold1", int'(a_busy), 1);
      step_idle(1);
      check_output("t2.busy_hold2", int'(a_busy), 1);
      step_idle(1);
      check_output("t2.busy_idle", int'(a_busy), 0);
      step_idle(4);
      check_output("t2.int_still_low", int'(a_int), 0);
      step_idle(1);
      check_output("t2.int_next_tick", int'(a_int), 1);

      // Writes to a neighbouring word and writes with no byte enables are not acks.
      apply_stimulus(1'b0, 32'h7F24, 4'b1111);
      check_output("t3.int_wrong_addr", int'(a_int), 1);
      apply_stimulus(1'b0, 32'h7F20, 4'b0000);
      check_output("t3.int_zero_byteen", int'(a_int), 1);
      check_output("t3.busy", int'(a_busy), 1);
      check_output("t3.b_idle", int'(b_int), 0);

      // With ticks disabled: the queue saturates at 3, then acks replay exactly three queued events.
      apply_stimulus(1'b1, 32'd0, 4'd0);
      check_output("t4.b_asserted", int'(b_int), 1);
      repeat (5) apply_stimulus(1'b1, 32'd0, 4'd0);
      step_idle(1);
      check_output("t4.b_saturated", int'(b_pend), 3);
      reasserts = 0;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 32'h7F20, 4'b1111);
         w = 0;
         while (b_int == 1'b0 && w < 10) begin
            step_idle(1);
            w++;
         end
         if (b_int) begin
            reasserts++;
            check_output("t4.low_cycles", w, HOLDOFF + 1);
         end
      end
      check_output("t4.reasserts", reasserts, 3);
      check_output("t4.b_final_int", int'(b_int), 0);
      check_output("t4.b_final_pend", int'(b_pend), 0);
      check_output("t4.b_final_busy", int'(b_busy), 0);

      // Async reset mid-ASSERT with two events queued clears all outputs before the next edge.
      reset = 1'b1;
      step_idle(2);
      reset = 1'b0;
      step_idle(8);
      check_output("t5.int_up", int'(a_int), 1);
      apply_stimulus(1'b1, 32'd0, 4'd0);
      apply_stimulus(1'b1, 32'd0, 4'd0);
      step_idle(0);
      check_output("t5.pend_before_reset", int'(a_pend), 2);
      #2 reset = 1'b1;
      #1;
      check_output("t5.async_int", int'(a_int), 0);
      check_output("t5.async_pend", int'(a_pend), 0);
      check_output("t5.async_busy", int'(a_busy), 0);
      @(negedge clk);
      reset = 1'b0;
      step_idle(7);
      check_output("t5.int_low_edge7", int'(a_int), 0);
      step_idle(1);
      check_output("t5.int_up_edge8", int'(a_int), 1);

      // Ack and trigger in the same cycle: the trigger is queued and replays after HOLD (2) + IDLE (1).
      apply_stimulus(1'b1, 32'h7F23, 4'b1000);
      check_output("t6.int_low1", int'(a_int), 0);
      check_output("t6.pend_queued", int'(a_pend), 1);
      step_idle(1);
      check_output("t6.int_low2", int'(a_int), 0);
      step_idle(1);
      check_output("t6.int_low3", int'(a_int), 0);
      step_idle(1);
      check_output("t6.int_high", int'(a_int), 1);
      check_output("t6.pend_drained", int'(a_pend), 0);

      // Random traffic mixes acks, near-miss addresses, triggers and occasional resets.
      addrs = '{32'h7F20, 32'h7F21, 32'h7F22, 32'h7F23, 32'h7F24, 32'h7F1C, 32'h0, 32'hFFFF_7F20};
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            step_idle(1);
            reset = 1'b0;
         end
         if ($urandom_range(0, 3) == 0)
            apply_stimulus($urandom_range(0, 5) == 0, addrs[$urandom_range(0, 7)], 4'($urandom_range(0, 15)));
         else
            apply_stimulus($urandom_range(0, 5) == 0, $urandom, 4'd0);
      end
      step_idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
